// File: rtl/dbg_trace_capture.sv
// -----------------------------------------------------------------------------
// dbg_trace_capture
//
// Purpose:
//   Debug-bus trace buffer. One of NUM_CH debug channels is captured into a
//   DEPTH-entry circular buffer. Capture runs continuously before the trigger
//   and for POST_TRIG more samples after it. The captured window is then
//   drained oldest-first over a valid/ready read port. A sticky error_fiq
//   flags protocol misuse (trig outside PRE/POST, arm outside IDLE).
//
// Optional feature:
//   DBG_TRACE_TSTAMP_EN - adds a 16-bit free-running timestamp. It is stored
//   with every sample, and rd_data becomes {ts[15:0], sample[DBG_W-1:0]}.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   dbg_bus    in   NUM_CH*DBG_W, channel c at [c*DBG_W +: DBG_W]
//   ch_sel     in   channel select, latched when arm is accepted
//   arm        in   start a capture (accepted in IDLE only)
//   trig       in   trigger (meaningful in PRE only)
//   rd_valid   out  read data valid
//   rd_ready   in   read data accepted
//   rd_data    out  captured sample (DBG_W, or DBG_W+16 with timestamp)
//   rd_last    out  final entry of the captured window
//   state      out  IDLE=0, PRE=1, POST=2, DUMP=3
//   error_fiq  out  sticky misuse flag
//   fiq_clr    in   clears error_fiq (a simultaneous set wins)
// -----------------------------------------------------------------------------
module dbg_trace_capture #(
    parameter int DBG_W     = 8,
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_CH*DBG_W-1:0]                     dbg_bus,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    input  logic                                        arm,
    input  logic                                        trig,
    output logic                                        rd_valid,
    input  logic                                        rd_ready,
`ifdef DBG_TRACE_TSTAMP_EN
    output logic [DBG_W+15:0]                           rd_data,
`else
    output logic [DBG_W-1:0]                            rd_data,
`endif
    output logic                                        rd_last,
    output logic [1:0]                                  state,
    output logic                                        error_fiq,
    input  logic                                        fiq_clr
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
`ifdef DBG_TRACE_TSTAMP_EN
    localparam int ENT_W = DBG_W + 16;
`else
    localparam int ENT_W = DBG_W;
`endif
    localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_LAST = (POST_TRIG > 0) ? CNT_W'(POST_TRIG - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    sel_q, sel_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   post_q, post_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]   ridx_q, ridx_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ENT_W-1:0]   rd_data_q, rd_data_d;
    logic               rd_last_q, rd_last_d;
    logic               fiq_q, fiq_d;
`ifdef DBG_TRACE_TSTAMP_EN
    logic [15:0]        ts_q, ts_d;
`endif

    logic [ENT_W-1:0]   buf_q [DEPTH];
    logic               wr_en;
    logic [ENT_W-1:0]   wr_entry;
    logic [DBG_W-1:0]   sample;
    logic [AW-1:0]      rd_start;
    logic [CNT_W-1:0]   fill_inc;
    logic               err_set;

    // Channel mux. An out-of-range select (non-power-of-2 NUM_CH) reads as zero.
    always_comb begin
        sample = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_q == CH_W'(c)) begin
                sample = dbg_bus[c*DBG_W +: DBG_W];
            end
        end
`ifdef DBG_TRACE_TSTAMP_EN
        wr_entry = {ts_q, sample};
`else
        wr_entry = sample;
`endif
    end

    // Sequencer: capture pointer/fill bookkeeping, dump read-out and the
    // misuse flag. The read-out register is loaded one cycle after entering
    // DUMP, so rd_valid first rises on the edge after the final write.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wptr_d     = wptr_q;
        fill_d     = fill_q;
        post_d     = post_q;
        rptr_d     = rptr_q;
        ridx_d     = ridx_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        wr_en      = 1'b0;
        fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        // Oldest valid entry; when full this wraps back onto wptr itself.
        rd_start   = wptr_q - fill_q[AW-1:0];

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_PRE;
                    sel_d   = ch_sel;
                    wptr_d  = '0;
                    fill_d  = '0;
                    post_d  = '0;
                end
            end
            ST_PRE: begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + 1'b1;
                fill_d = fill_inc;
                if (trig) begin
                    state_d = (POST_TRIG == 0) ? ST_DUMP : ST_POST;
                end
            end
            ST_POST: begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + 1'b1;
                fill_d = fill_inc;
                post_d = post_q + 1'b1;
                if (post_q == POST_LAST) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (!rd_valid_q) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = buf_q[rd_start];
                    rd_last_d  = (fill_q == CNT_W'(1));
                    rptr_d     = rd_start + 1'b1;
                    ridx_d     = CNT_W'(1);
                end else if (rd_ready) begin
                    if (rd_last_q) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        rd_data_d  = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        rd_data_d = buf_q[rptr_q];
                        rd_last_d = (ridx_q == fill_q - 1'b1);
                        rptr_d    = rptr_q + 1'b1;
                        ridx_d    = ridx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_set = (trig && ((state_q == ST_IDLE) || (state_q == ST_DUMP))) ||
                  (arm && (state_q != ST_IDLE));
        fiq_d   = err_set | (fiq_q & ~fiq_clr);
`ifdef DBG_TRACE_TSTAMP_EN
        ts_d    = ts_q + 16'd1;
`endif
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            wptr_q     <= '0;
            fill_q     <= '0;
            post_q     <= '0;
            rptr_q     <= '0;
            ridx_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            fiq_q      <= 1'b0;
`ifdef DBG_TRACE_TSTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            wptr_q     <= wptr_d;
            fill_q     <= fill_d;
            post_q     <= post_d;
            rptr_q     <= rptr_d;
            ridx_q     <= ridx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            fiq_q      <= fiq_d;
`ifdef DBG_TRACE_TSTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    // Trace storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wptr_q] <= wr_entry;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;
    assign state     = state_q;
    assign error_fiq = fiq_q;

endmodule
